// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder.
// Digit width, largest legal BCD digit and FSM state encoding.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_step.sv
// Combinational single-digit BCD add/subtract step.
// Subtraction uses the nine's complement of b plus an inverted borrow.
module bcd_digit_step
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_d,
    input  logic [DIGIT_W-1:0] b_d,
    input  logic               sub,
    input  logic               c_in,
    output logic [DIGIT_W-1:0] digit,
    output logic               c_out
);

    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W:0]   t;

    // Binary digit sum, then decimal correction when it passes nine.
    always_comb begin
        b_eff = sub ? (BCD_MAX - b_d) : b_d;
        t = {1'b0, a_d}
          + {1'b0, b_eff}
          + {{DIGIT_W{1'b0}}, c_in};
        if (t > {1'b0, BCD_MAX}) begin
            digit = t[DIGIT_W-1:0] + DIGIT_W'(6);
            c_out = 1'b1;
        end else begin
            digit = t[DIGIT_W-1:0];
            c_out = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder/subtractor, one digit per clock, LSD first.
// Operands and result live in shift registers; one digit step is shared.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      sub,
    input  logic [DIGITS*DIGIT_W-1:0] a,
    input  logic [DIGITS*DIGIT_W-1:0] b,
    input  logic                      cin,
    output logic                      ready,
    output logic                      done,
    output logic [DIGITS*DIGIT_W-1:0] sum,
    output logic                      cout,
    output logic                      err
);

    localparam int W     = DIGITS * DIGIT_W;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    state_t state;
    state_t state_nx;

    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     sum_q;
    logic [IDX_W-1:0] idx_q;
    logic             c_q;
    logic             sub_q;
    logic             cout_q;
    logic             err_q;

    logic               bad;
    logic               last;
    logic [DIGIT_W-1:0] step_digit;
    logic               step_c;
    logic [W+DIGIT_W-1:0] sum_cat;

    // Low digit of each operand shift register feeds the shared step.
    bcd_digit_step u_step (
        .a_d   (a_q[DIGIT_W-1:0]),
        .b_d   (b_q[DIGIT_W-1:0]),
        .sub   (sub_q),
        .c_in  (c_q),
        .digit (step_digit),
        .c_out (step_c)
    );

    // Flag any non-BCD digit on the incoming operands.
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[i*DIGIT_W +: DIGIT_W] > BCD_MAX)
                bad = 1'b1;
            if (b[i*DIGIT_W +: DIGIT_W] > BCD_MAX)
                bad = 1'b1;
        end
    end

    assign last    = (idx_q == LAST);
    assign sum_cat = {step_digit, sum_q};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic: bad operands skip straight to DONE.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = bad ? DONE : RUN;
            end
            RUN: begin
                if (last)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture on accept, shift one digit per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            idx_q  <= '0;
            c_q    <= 1'b0;
            sub_q  <= 1'b0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        sub_q  <= sub;
                        c_q    <= sub ? ~cin : cin;
                        idx_q  <= '0;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        err_q  <= bad;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> DIGIT_W;
                    b_q   <= b_q >> DIGIT_W;
                    sum_q <= sum_cat[W+DIGIT_W-1:DIGIT_W];
                    c_q   <= step_c;
                    idx_q <= idx_q + 1'b1;
                    if (last)
                        cout_q <= step_c;
                end
                default: begin
                end
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign done  = (state == DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign err   = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed testbench for bcd_serial_adder with DIGITS=4.
// Each task drives one scenario and checks against hand-computed values.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub   = 1'b0;
    logic        cin   = 1'b0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic        ready;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    int ncmp  = 0;
    int nfail = 0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drive one request, scramble inputs after accept, wait for done.
    task automatic do_op(
        input  logic [15:0] av,
        input  logic [15:0] bv,
        input  logic        sv,
        input  logic        cv,
        output int          lat,
        output logic [15:0] s,
        output logic        co,
        output logic        er
    );
        @(negedge clk);
        a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'h5555; b = 16'h7777; sub = ~sv; cin = ~cv;
        lat = 1;
        @(negedge clk);
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        s = sum; co = cout; er = err;
    endtask

    task automatic test_reset;
        logic [19:0] obs;
        int          n;
        #1;
        obs = {ready, done, cout, err, sum};
        ncmp++;
        if (obs !== {4'b1000, 16'h0000}) begin
            nfail++;
            $display("FAIL reset_state: got %h want %h",
                     obs, {4'b1000, 16'h0000});
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = 16'h0042; b = 16'h0058; sub = 1'b0; cin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ncmp++;
        if (ready !== 1'b0) begin
            nfail++;
            $display("FAIL first_accept: ready=%b want 0", ready);
        end
        n = 1;
        @(negedge clk);
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        ncmp++;
        if ({sum, cout, err} !== {16'h0100, 2'b00}) begin
            nfail++;
            $display("FAIL first_op: sum=%h cout=%b err=%b want 0100 0 0",
                     sum, cout, err);
        end
        ncmp++;
        if (n !== 5) begin
            nfail++;
            $display("FAIL first_op_latency: got %0d want 5", n);
        end
    endtask

    task automatic test_add;
        int          lat;
        logic [15:0] s;
        logic        co;
        logic        er;
        do_op(16'h1234, 16'h5678, 1'b0, 1'b0, lat, s, co, er);
        ncmp++;
        if ({s, co, er} !== {16'h6912, 2'b00}) begin
            nfail++;
            $display("FAIL add_1234_5678: sum=%h cout=%b err=%b want 6912 0 0",
                     s, co, er);
        end
        ncmp++;
        if (lat !== 5) begin
            nfail++;
            $display("FAIL add_latency: got %0d want 5", lat);
        end
        @(negedge clk);
        ncmp++;
        if ({done, ready, sum, cout} !== {2'b01, 16'h6912, 1'b0}) begin
            nfail++;
            $display("FAIL add_hold: done=%b ready=%b sum=%h cout=%b",
                     done, ready, sum, cout);
        end
        do_op(16'h9999, 16'h0001, 1'b0, 1'b0, lat, s, co, er);
        ncmp++;
        if ({s, co} !== {16'h0000, 1'b1}) begin
            nfail++;
            $display("FAIL add_9999_0001: sum=%h cout=%b want 0000 1", s, co);
        end
        do_op(16'h0458, 16'h0367, 1'b0, 1'b1, lat, s, co, er);
        ncmp++;
        if ({s, co} !== {16'h0826, 1'b0}) begin
            nfail++;
            $display("FAIL add_cin: sum=%h cout=%b want 0826 0", s, co);
        end
    endtask

    task automatic test_max_wrap;
        int          lat;
        logic [15:0] s;
        logic        co;
        logic        er;
        do_op(16'h9999, 16'h9999, 1'b0, 1'b1, lat, s, co, er);
        ncmp++;
        if ({s, co, er} !== {16'h9999, 2'b10}) begin
            nfail++;
            $display("FAIL max_wrap: sum=%h cout=%b err=%b want 9999 1 0",
                     s, co, er);
        end
    endtask

    task automatic test_sub;
        int          lat;
        logic [15:0] s;
        logic        co;
        logic        er;
        do_op(16'h5000, 16'h1234, 1'b1, 1'b0, lat, s, co, er);
        ncmp++;
        if ({s, co} !== {16'h3766, 1'b1}) begin
            nfail++;
            $display("FAIL sub_5000_1234: sum=%h cout=%b want 3766 1", s, co);
        end
        ncmp++;
        if (lat !== 5) begin
            nfail++;
            $display("FAIL sub_latency: got %0d want 5", lat);
        end
        do_op(16'h1234, 16'h5678, 1'b1, 1'b0, lat, s, co, er);
        ncmp++;
        if ({s, co} !== {16'h5556, 1'b0}) begin
            nfail++;
            $display("FAIL sub_1234_5678: sum=%h cout=%b want 5556 0", s, co);
        end
        do_op(16'h5000, 16'h1234, 1'b1, 1'b1, lat, s, co, er);
        ncmp++;
        if ({s, co} !== {16'h3765, 1'b1}) begin
            nfail++;
            $display("FAIL sub_borrow_in: sum=%h cout=%b want 3765 1", s, co);
        end
        do_op(16'h0000, 16'h0000, 1'b1, 1'b1, lat, s, co, er);
        ncmp++;
        if ({s, co} !== {16'h9999, 1'b0}) begin
            nfail++;
            $display("FAIL sub_zero_minus_one: sum=%h cout=%b want 9999 0",
                     s, co);
        end
    endtask

    task automatic test_err;
        int          lat;
        logic [15:0] s;
        logic        co;
        logic        er;
        do_op(16'h12A4, 16'h0001, 1'b0, 1'b0, lat, s, co, er);
        ncmp++;
        if ({s, co, er} !== {16'h0000, 2'b01}) begin
            nfail++;
            $display("FAIL err_a: sum=%h cout=%b err=%b want 0000 0 1",
                     s, co, er);
        end
        ncmp++;
        if (lat !== 1) begin
            nfail++;
            $display("FAIL err_latency: got %0d want 1", lat);
        end
        do_op(16'h0001, 16'h0002, 1'b0, 1'b0, lat, s, co, er);
        ncmp++;
        if ({s, co, er} !== {16'h0003, 2'b00}) begin
            nfail++;
            $display("FAIL err_clear: sum=%h cout=%b err=%b want 0003 0 0",
                     s, co, er);
        end
        do_op(16'h0001, 16'h000F, 1'b1, 1'b0, lat, s, co, er);
        ncmp++;
        if ({s, co, er, lat} !== {16'h0000, 2'b01, 32'd1}) begin
            nfail++;
            $display("FAIL err_b: sum=%h cout=%b err=%b lat=%0d want 0000 0 1 1",
                     s, co, er, lat);
        end
    endtask

    task automatic test_ignore_start;
        int n;
        int extra;
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; sub = 1'b0; cin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        @(negedge clk);
        a = 16'h9999; b = 16'h9999; sub = 1'b1; cin = 1'b1;
        start = 1'b1;
        @(negedge clk);
        n++;
        @(negedge clk);
        n++;
        start = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        ncmp++;
        if ({sum, cout, err} !== {16'h6912, 2'b00}) begin
            nfail++;
            $display("FAIL ignore_start: sum=%h cout=%b err=%b want 6912 0 0",
                     sum, cout, err);
        end
        ncmp++;
        if (n !== 5) begin
            nfail++;
            $display("FAIL ignore_latency: got %0d want 5", n);
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || !ready)
                extra++;
        end
        ncmp++;
        if (extra !== 0) begin
            nfail++;
            $display("FAIL ignore_no_relaunch: busy cycles=%0d want 0", extra);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [19:0] obs;
        int          seen;
        int          lat;
        logic [15:0] s;
        logic        co;
        logic        er;
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; sub = 1'b0; cin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        obs = {ready, done, cout, err, sum};
        ncmp++;
        if (obs !== {4'b1000, 16'h0000}) begin
            nfail++;
            $display("FAIL mid_run_reset: got %h want %h",
                     obs, {4'b1000, 16'h0000});
        end
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done)
                seen++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done)
                seen++;
        end
        ncmp++;
        if (seen !== 0) begin
            nfail++;
            $display("FAIL mid_run_no_done: done cycles=%0d want 0", seen);
        end
        do_op(16'h1234, 16'h5678, 1'b0, 1'b0, lat, s, co, er);
        ncmp++;
        if ({s, co, er, lat} !== {16'h6912, 2'b00, 32'd5}) begin
            nfail++;
            $display("FAIL after_reset_op: sum=%h cout=%b err=%b lat=%0d",
                     s, co, er, lat);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_max_wrap();
        test_sub();
        test_err();
        test_ignore_start();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder.md
BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 Parameter: DIGITS, default 4, number of BCD digits per operand (legal range 1..16).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; accepted only when ready=1.
REQ-005 sub  input  1  mode: 0 = A+B+cin, 1 = A-B-cin (cin as borrow-in).
REQ-006 a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
REQ-007 b  input  4*DIGITS  operand B, packed BCD.
REQ-008 cin  input  1  carry-in (add) / borrow-in (sub).
REQ-009 ready  output  1  high in IDLE only.
REQ-010 done  output  1  one-cycle pulse when result valid.
REQ-011 sum  output  4*DIGITS  packed BCD result.
REQ-012 cout  output  1  add: decimal carry-out; sub: 1 = no borrow, 0 = borrow.
REQ-013 err  output  1  set when any accepted operand digit exceeds 9.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
REQ-015 IDLE with start=1: capture a, b, sub, cin; clear digit index; go to RUN, or DONE if the error check fails.
REQ-016 Capture-time check: any 4-bit digit of a or b >9 SHALL set err=1, sum=0, cout=0, and skip RUN.
REQ-017 RUN processes one digit per cycle, least-significant first, using the stored inter-digit carry.
REQ-018 Digit step: t = a_i + b'_i + c; if t>9, digit = t+6 (mod 16) and c = 1, else digit = t and c = 0.
REQ-019 b'_i = b_i in add mode and 9-b_i in sub mode; initial c = cin in add mode and !cin in sub mode.
REQ-020 Sub mode with final c=0 SHALL yield the ten's-complement result 10^DIGITS + A - B - cin.
REQ-021 RUN lasts exactly DIGITS cycles; after the last digit, cout = final c, go to DONE.
REQ-022 DONE lasts one cycle with done=1, then IDLE; latency from accepting edge to done = DIGITS+1 cycles (1 cycle on err path).
REQ-023 sum, cout, err SHALL hold from done until the next accepted start, which clears err.
REQ-024 start while ready=0 SHALL be ignored with no effect on the operation in progress.
REQ-025 Changes on a, b, sub, cin after capture SHALL NOT affect the result.
REQ-026 Inputs 9..9 + 9..9 + cin=1 SHALL give sum all-9 and cout=1 (maximum wrap case).

Reset
REQ-027 rst_n low SHALL immediately force IDLE, ready=1, done=0, sum=0, cout=0, err=0, carry and index=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation without producing a done pulse.
REQ-029 First start is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package bcd_pkg SHALL hold the state enum, DIGIT_W=4 and BCD_MAX=9.
REQ-031 Sub-module bcd_digit_step SHALL implement the combinational single-digit step of REQ-018/019, instantiated once.
REQ-032 Datapath SHALL be a shift register of operands and result, shifting by one digit per RUN cycle, with no DIGITS-wide ripple chain.

Verification (DIGITS=4)
REQ-033 Add 1234+5678, cin=0 -> sum=6912, cout=0, done 5 cycles after accept.
REQ-034 Add 9999+0001, cin=0 -> sum=0000, cout=1; 9999+9999, cin=1 -> sum=9999, cout=1.
REQ-035 Sub 5000-1234, cin=0 -> sum=3766, cout=1; 1234-5678 -> sum=5556, cout=0.
REQ-036 a=0x12A4 -> err=1, sum=0, cout=0, done 1 cycle after accept; next valid op clears err.
REQ-037 start pulsed during RUN with new operands -> ignored, first result unchanged.
REQ-038 rst_n low in the second RUN cycle -> outputs zero, no done pulse; new op after release completes correctly.
